// File: rtl/video_geometry_detector.sv
// Measures active width/height from DE/VSYNC, qualifies the geometry over
// LOCK_FRAMES identical frames, and emits line/frame event pulses.
module video_geometry_detector #(
  parameter int MAX_WIDTH         = 1920,
  parameter int MAX_HEIGHT        = 1080,
  parameter int LOCK_FRAMES       = 2,
  parameter int VSYNC_ACTIVE_HIGH = 1,
  localparam int W = $clog2(MAX_WIDTH),
  localparam int H = $clog2(MAX_HEIGHT)
) (
  input  logic         I_clk,
  input  logic         I_rst,
  input  logic         I_de,
  input  logic         I_vsync,
  output logic [W-1:0] O_image_width,
  output logic [H-1:0] O_image_height,
  output logic         O_image_valid,
  output logic         O_next_column,
  output logic         O_next_image,
  output logic         O_frame_complete
);

  localparam logic [W:0] PX_MAX = (W+1)'(MAX_WIDTH);
  localparam logic [W:0] PX_SAT = (W+1)'(MAX_WIDTH + 1);
  localparam logic [H:0] LN_MAX = (H+1)'(MAX_HEIGHT);
  localparam logic [H:0] LN_SAT = (H+1)'(MAX_HEIGHT + 1);
  localparam logic [3:0] LOCK   = 4'(LOCK_FRAMES);

  typedef enum logic {SYNC_WAIT, MEASURE} state_t;

  state_t       r_state, w_state_nxt;
  logic         w_measure;

  logic         r_de_d, r_vs_d;
  logic         w_vs_act, w_vs_edge, w_de_rise, w_de_fall;

  logic [W:0]   r_px_cnt, w_px_nxt;
  logic         r_in_line, w_in_line_nxt;
  logic         w_px_ovf;

  logic [H:0]   r_line_cnt, w_lc_n;
  logic [W:0]   r_first_w, w_fw_n;
  logic         r_mismatch, w_mm_n;
  logic         r_ovf, w_ovf_n;
  logic         w_line_done;

  logic [W:0]   r_cand_w;
  logic [H:0]   r_cand_h;
  logic [3:0]   r_match_cnt, w_match_nxt;
  logic         w_frame_end, w_good, w_match, w_first_rise;

  logic [W-1:0] r_width;
  logic [H-1:0] r_height;
  logic         r_valid, r_next_column, r_next_image, r_frame_complete;

  assign w_vs_act  = (VSYNC_ACTIVE_HIGH != 0) ? I_vsync : ~I_vsync;
  assign w_vs_edge = w_vs_act & ~r_vs_d;
  assign w_de_rise = I_de & ~r_de_d;
  assign w_de_fall = ~I_de & r_de_d;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) r_state <= SYNC_WAIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SYNC_WAIT: if (w_vs_edge) w_state_nxt = MEASURE;
      MEASURE:   w_state_nxt = MEASURE;
      default:   w_state_nxt = SYNC_WAIT;
    endcase
  end

  always_comb begin
    w_measure = (r_state == MEASURE);
  end

  // A line is only tracked if its rising edge was seen while measuring.
  always_comb begin
    w_px_nxt      = r_px_cnt;
    w_px_ovf      = 1'b0;
    w_in_line_nxt = r_in_line;
    if (w_measure) begin
      if (w_de_rise) begin
        w_px_nxt      = {{W{1'b0}}, 1'b1};
        w_in_line_nxt = 1'b1;
      end else if (w_de_fall) begin
        w_in_line_nxt = 1'b0;
      end else if (I_de && r_in_line) begin
        if (r_px_cnt >= PX_MAX) begin
          w_px_nxt = PX_SAT;
          w_px_ovf = 1'b1;
        end else begin
          w_px_nxt = r_px_cnt + 1'b1;
        end
      end
    end
  end

  // Per-frame values including a line that ends this cycle, so a de_fall
  // coincident with vs_edge is counted into the ending frame.
  always_comb begin
    w_line_done = w_measure & w_de_fall & r_in_line;
    w_lc_n      = r_line_cnt;
    w_fw_n      = r_first_w;
    w_mm_n      = r_mismatch;
    w_ovf_n     = r_ovf | w_px_ovf;
    if (w_line_done) begin
      if (r_line_cnt == '0)            w_fw_n = r_px_cnt;
      else if (r_px_cnt != r_first_w)  w_mm_n = 1'b1;
      if (r_line_cnt >= LN_MAX) begin
        w_lc_n  = LN_SAT;
        w_ovf_n = 1'b1;
      end else begin
        w_lc_n  = r_line_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_frame_end  = w_measure & w_vs_edge;
    w_good       = ~w_mm_n & ~w_ovf_n & (w_fw_n <= PX_MAX) & (w_lc_n <= LN_MAX);
    w_match      = (w_fw_n == r_cand_w) && (w_lc_n == r_cand_h);
    w_match_nxt  = 4'd1;
    if (w_match) w_match_nxt = (r_match_cnt == 4'hF) ? 4'hF : r_match_cnt + 4'd1;
    w_first_rise = w_measure & w_de_rise & (w_vs_edge | (r_line_cnt == '0));
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_de_d           <= 1'b0;
      r_vs_d           <= 1'b0;
      r_px_cnt         <= '0;
      r_in_line        <= 1'b0;
      r_line_cnt       <= '0;
      r_first_w        <= '0;
      r_mismatch       <= 1'b0;
      r_ovf            <= 1'b0;
      r_cand_w         <= '0;
      r_cand_h         <= '0;
      r_match_cnt      <= '0;
      r_width          <= '0;
      r_height         <= '0;
      r_valid          <= 1'b0;
      r_next_column    <= 1'b0;
      r_next_image     <= 1'b0;
      r_frame_complete <= 1'b0;
    end else begin
      r_de_d           <= I_de;
      r_vs_d           <= w_vs_act;
      r_px_cnt         <= w_px_nxt;
      r_in_line        <= w_in_line_nxt;
      r_next_column    <= w_line_done;
      r_next_image     <= w_first_rise;
      r_frame_complete <= 1'b0;
      if (w_frame_end) begin
        r_line_cnt <= '0;
        r_first_w  <= '0;
        r_mismatch <= 1'b0;
        r_ovf      <= 1'b0;
        if (w_lc_n == '0) begin
          r_valid     <= 1'b0;
          r_match_cnt <= '0;
        end else begin
          r_frame_complete <= 1'b1;
          if (w_good) begin
            r_match_cnt <= w_match_nxt;
            r_cand_w    <= w_fw_n;
            r_cand_h    <= w_lc_n;
            r_width     <= w_fw_n[W-1:0];
            r_height    <= w_lc_n[H-1:0];
            r_valid     <= (w_match_nxt >= LOCK);
          end else begin
            r_valid     <= 1'b0;
            r_match_cnt <= '0;
            r_cand_w    <= '0;
            r_cand_h    <= '0;
          end
        end
      end else begin
        r_line_cnt <= w_lc_n;
        r_first_w  <= w_fw_n;
        r_mismatch <= w_mm_n;
        r_ovf      <= w_ovf_n;
      end
    end
  end

  assign O_image_width    = r_width;
  assign O_image_height   = r_height;
  assign O_image_valid    = r_valid;
  assign O_next_column    = r_next_column;
  assign O_next_image     = r_next_image;
  assign O_frame_complete = r_frame_complete;

endmodule

// File: tb/tb_video_geometry_detector.sv
// Self-checking bench: frame table drives stimulus, a scoreboard queue holds
// expected per-frame results compared when O_frame_complete fires.
module tb_video_geometry_detector;

  localparam int MW = 64;
  localparam int MH = 32;
  localparam int WB = $clog2(MW);
  localparam int HB = $clog2(MH);

  logic          clk = 1'b0;
  logic          rst, de, vsync;
  logic [WB-1:0] o_w;
  logic [HB-1:0] o_h;
  logic          o_valid, o_col, o_img, o_fc;

  video_geometry_detector #(
    .MAX_WIDTH        (MW),
    .MAX_HEIGHT       (MH),
    .LOCK_FRAMES      (2),
    .VSYNC_ACTIVE_HIGH(1)
  ) dut (
    .I_clk           (clk),
    .I_rst           (rst),
    .I_de            (de),
    .I_vsync         (vsync),
    .O_image_width   (o_w),
    .O_image_height  (o_h),
    .O_image_valid   (o_valid),
    .O_next_column   (o_col),
    .O_next_image    (o_img),
    .O_frame_complete(o_fc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w; int h; int short_line;
    int exp_w; int exp_h; bit exp_v;
  } vec_t;

  typedef struct {
    int w; int h; bit v; int cols; int imgs;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   col_cnt = 0;
  int   img_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drive_lines(input int w, input int h, input int short_line);
    for (int l = 0; l < h; l++) begin
      int len;
      len = (l == short_line) ? w - 1 : w;
      de = 1'b1;
      repeat (len) tick();
      de = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic push_exp(input int w, input int h, input bit v, input int cols);
    exp_t e;
    e.w = w; e.h = h; e.v = v; e.cols = cols; e.imgs = 1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      col_cnt = 0;
      img_cnt = 0;
    end else begin
      if (o_col) col_cnt++;
      if (o_img) img_cnt++;
      if (o_fc) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame_complete", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("frame_width",   int'(o_w),     e.w);
          chk("frame_height",  int'(o_h),     e.h);
          chk("frame_valid",   int'(o_valid), int'(e.v));
          chk("next_column_n", col_cnt,       e.cols);
          chk("next_image_n",  img_cnt,       e.imgs);
        end
        col_cnt = 0;
        img_cnt = 0;
      end
    end
  end

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{16, 8, -1, 16, 8, 1'b0};
    tbl[1]  = '{16, 8, -1, 16, 8, 1'b1};
    tbl[2]  = '{16, 8, -1, 16, 8, 1'b1};
    tbl[3]  = '{16, 8,  2, 16, 8, 1'b0};
    tbl[4]  = '{16, 8, -1, 16, 8, 1'b0};
    tbl[5]  = '{16, 8, -1, 16, 8, 1'b1};
    tbl[6]  = '{32, 4, -1, 32, 4, 1'b0};
    tbl[7]  = '{32, 4, -1, 32, 4, 1'b1};
    tbl[8]  = '{70, 4, -1, 32, 4, 1'b0};
    tbl[9]  = '{16, 8, -1, 16, 8, 1'b0};
    tbl[10] = '{16, 8, -1, 16, 8, 1'b1};
    tbl[11] = '{16, 8, -1, 16, 8, 1'b1};
    tbl[12] = '{16, 8, -1, 16, 8, 1'b1};

    rst = 1'b1; de = 1'b0; vsync = 1'b0;
    repeat (3) tick();
    chk("rst_width",  int'(o_w),     0);
    chk("rst_height", int'(o_h),     0);
    chk("rst_valid",  int'(o_valid), 0);
    chk("rst_col",    int'(o_col),   0);
    chk("rst_img",    int'(o_img),   0);
    chk("rst_fc",     int'(o_fc),    0);
    rst = 1'b0;
    repeat (2) tick();
    vsync_pulse();

    for (int i = 0; i < 13; i++) begin
      push_exp(tbl[i].exp_w, tbl[i].exp_h, tbl[i].exp_v, tbl[i].h);
      drive_lines(tbl[i].w, tbl[i].h, tbl[i].short_line);
      vsync_pulse();
    end
    chk("table_drained", sb.size(), 0);

    // VSYNC with no active lines: no frame_complete, valid drops, geometry holds.
    vsync_pulse();
    vsync_pulse();
    chk("novideo_valid",  int'(o_valid), 0);
    chk("novideo_width",  int'(o_w),     16);
    chk("novideo_height", int'(o_h),     8);

    // Reset in the middle of line 4.
    vsync_pulse();
    drive_lines(16, 3, -1);
    de = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("midrst_width",  int'(o_w),     0);
    chk("midrst_height", int'(o_h),     0);
    chk("midrst_valid",  int'(o_valid), 0);
    tick();
    de = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    drive_lines(16, 2, -1);
    chk("presync_cols", col_cnt, 0);
    chk("presync_imgs", img_cnt, 0);
    vsync_pulse();
    push_exp(16, 8, 1'b0, 8);
    drive_lines(16, 8, -1);
    vsync_pulse();
    push_exp(16, 8, 1'b1, 8);
    drive_lines(16, 8, -1);
    vsync_pulse();

    // Last DE falling edge coincides with the VSYNC leading edge.
    push_exp(16, 8, 1'b1, 8);
    drive_lines(16, 7, -1);
    de = 1'b1;
    repeat (16) tick();
    de = 1'b0;
    vsync = 1'b1;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (3) tick();

    for (int t = 0; t < 50 && sb.size() != 0; t++) tick();
    chk("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
